mult_chip: RTL and testbench
============================

MULT_CHIP -- requirements
Module: mult_chip

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port i_smem_ext, input, 1, 1 = signature memory owned by external port, 0 = owned by internal logger.
REQ-004 SHALL have port i_smem_cen, input, 1, external chip enable, active-low.
REQ-005 SHALL have port i_smem_wen, input, 1, external write enable, active-low (1 = read).
REQ-006 SHALL have port i_smem_addr, input, 12, external word address (0..4095).
REQ-007 SHALL have port i_smem_wdata, input, 16, external write data.
REQ-008 SHALL have port o_smem_rdata, output, 16, registered external read data.

Function
REQ-009 SHALL contain a 4096 x 16 single-port signature memory (SMEM), one access per cycle.
REQ-010 SHALL contain a 16-bit Fibonacci LFSR, taps 16,14,13,11: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-011 SHALL form operands A = lfsr[15:8], B = lfsr[7:0], unsigned; product P = A*B, full 16-bit, no truncation.
REQ-012 SHALL contain a 12-bit write pointer wr_addr and a 1-bit done flag.
REQ-013 Logging cycle (i_smem_ext=0, done=0): write the P of the current LFSR state to SMEM[wr_addr], then advance LFSR and increment wr_addr, in the same edge.
REQ-014 After the write to address 4095, done SHALL set; no further internal writes; LFSR and wr_addr freeze (no wrap-around).
REQ-015 While i_smem_ext=1, logging SHALL pause (LFSR, wr_addr, pipeline frozen, no internal write) and resume unchanged when i_smem_ext returns to 0.
REQ-016 External mode: i_smem_cen=0, i_smem_wen=0 writes i_smem_wdata to SMEM[i_smem_addr]; i_smem_cen=0, i_smem_wen=1 reads.
REQ-017 Read latency SHALL be 1 cycle: data of the addressed word appears on o_smem_rdata after the rising edge that samples the read.
REQ-018 o_smem_rdata SHALL hold its last value when no external read occurs, including during internal writes; i_smem_cen=1 means no access.
REQ-019 External write and read of the same address in consecutive cycles SHALL return the new data.

Reset
REQ-020 i_reset=1 at a rising edge SHALL load lfsr=16'hACE1, wr_addr=0, done=0, pipeline valid=0, o_smem_rdata=16'h0000.
REQ-021 SMEM contents SHALL NOT be cleared by reset; reset mid-logging restarts logging from address 0 with the seed.
REQ-022 While i_reset=1, no SMEM write SHALL occur; logging starts on the first edge with i_reset=0.

Configuration
REQ-023 Macro MULT_PIPE_EN SHALL, when defined, insert one register stage (product + address + valid) between the multiplier and the SMEM write port; first write occurs one cycle later.
REQ-024 Without MULT_PIPE_EN, P SHALL be written combinationally in the same cycle; in both builds SMEM contents after completion SHALL be identical.
REQ-025 With MULT_PIPE_EN, the pipeline register SHALL drain its pending entry before done sets; pause per REQ-015 also freezes that stage.

Verification
REQ-026 Reset, run 4100+ cycles with i_smem_ext=0, then ext read addr 0 -> 16'h972C (0xAC*0xE1); addr 1 -> 16'h43CB (0x59*0xC3).
REQ-027 Full log, ext read all 4096 addresses -> each equals the product of the LFSR sequence from 16'hACE1, the value at addr 4095 unchanged after 8192 further cycles (no wrap).
REQ-028 Assert i_smem_ext=1 for 100 cycles at cycle 500 of logging -> final contents identical to an uninterrupted run.
REQ-029 Ext write 16'hBEEF to addr 12'd7 after done, read next cycle -> o_smem_rdata=16'hBEEF one cycle after the read edge; o_smem_rdata holds when i_smem_cen=1.
REQ-030 Reset asserted at logging cycle 1000 for 2 cycles -> o_smem_rdata=0, logging restarts, addr 0 again 16'h972C; repeat all in both MULT_PIPE_EN builds -> identical memory dumps.

Source files
------------

// File: rtl/mult_chip.sv
// Self-logging multiplier: an LFSR feeds an 8x8 multiplier whose products fill a 4096x16 signature memory,
// which an external port can own for reads/writes. Optional macro MULT_PIPE_EN adds one write-side register stage.
module mult_chip (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_smem_ext,
   input  logic        i_smem_cen,
   input  logic        i_smem_wen,
   input  logic [11:0] i_smem_addr,
   input  logic [15:0] i_smem_wdata,
   output logic [15:0] o_smem_rdata
);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [11:0] LAST_ADDR = 12'hFFF;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
   endfunction

   logic [15:0] smem_q [0:4095];
   logic [15:0] lfsr_q, lfsr_d;
   logic [11:0] wr_addr_q, wr_addr_d;
   logic        done_q, done_d;
   logic [15:0] rdata_q;
   logic [15:0] product_s;
   logic        log_run_s;
   logic        int_we_s;
   logic [11:0] int_addr_s;
   logic [15:0] int_wdata_s;
   logic        mem_we_s;
   logic [11:0] mem_addr_s;
   logic [15:0] mem_wdata_s;

   assign product_s = 16'(lfsr_q[15:8]) * 16'(lfsr_q[7:0]);
   assign log_run_s = !i_smem_ext && !i_reset;

`ifdef MULT_PIPE_EN
   // issue_done marks the last product entering the stage; done waits for it to drain
   logic        issue_done_q, issue_done_d;
   logic        pipe_valid_q, pipe_valid_d;
   logic [11:0] pipe_addr_q, pipe_addr_d;
   logic [15:0] pipe_data_q, pipe_data_d;

   always_comb begin
      lfsr_d       = lfsr_q;
      wr_addr_d    = wr_addr_q;
      done_d       = done_q;
      issue_done_d = issue_done_q;
      pipe_valid_d = pipe_valid_q;
      pipe_addr_d  = pipe_addr_q;
      pipe_data_d  = pipe_data_q;
      int_we_s     = 1'b0;
      int_addr_s   = pipe_addr_q;
      int_wdata_s  = pipe_data_q;
      if (log_run_s) begin
         if (!issue_done_q) begin
            pipe_valid_d = 1'b1;
            pipe_addr_d  = wr_addr_q;
            pipe_data_d  = product_s;
            if (wr_addr_q == LAST_ADDR) begin
               issue_done_d = 1'b1;
            end else begin
               wr_addr_d = wr_addr_q + 12'd1;
               lfsr_d    = lfsr_next(lfsr_q);
            end
         end else begin
            pipe_valid_d = 1'b0;
         end
         if (pipe_valid_q) begin
            int_we_s = 1'b1;
            if (pipe_addr_q == LAST_ADDR) begin
               done_d = 1'b1;
            end else begin
               done_d = done_q;
            end
         end else begin
            int_we_s = 1'b0;
         end
      end else begin
         int_we_s = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         issue_done_q <= 1'b0;
         pipe_valid_q <= 1'b0;
         pipe_addr_q  <= 12'd0;
         pipe_data_q  <= 16'd0;
      end else begin
         issue_done_q <= issue_done_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_addr_q  <= pipe_addr_d;
         pipe_data_q  <= pipe_data_d;
      end
   end
`else
   always_comb begin
      lfsr_d      = lfsr_q;
      wr_addr_d   = wr_addr_q;
      done_d      = done_q;
      int_we_s    = 1'b0;
      int_addr_s  = wr_addr_q;
      int_wdata_s = product_s;
      if (log_run_s && !done_q) begin
         int_we_s = 1'b1;
         if (wr_addr_q == LAST_ADDR) begin
            done_d = 1'b1;
         end else begin
            wr_addr_d = wr_addr_q + 12'd1;
            lfsr_d    = lfsr_next(lfsr_q);
         end
      end else begin
         int_we_s = 1'b0;
      end
   end
`endif

   // Port ownership mux; reset blocks every write
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = int_addr_s;
      mem_wdata_s = int_wdata_s;
      if (i_reset) begin
         mem_we_s = 1'b0;
      end else if (i_smem_ext) begin
         mem_we_s    = !i_smem_cen && !i_smem_wen;
         mem_addr_s  = i_smem_addr;
         mem_wdata_s = i_smem_wdata;
      end else begin
         mem_we_s = int_we_s;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         lfsr_q    <= LFSR_SEED;
         wr_addr_q <= 12'd0;
         done_q    <= 1'b0;
      end else begin
         lfsr_q    <= lfsr_d;
         wr_addr_q <= wr_addr_d;
         done_q    <= done_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we_s) begin
         smem_q[mem_addr_s] <= mem_wdata_s;
      end
   end

   // Read data only changes on an external read
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rdata_q <= 16'h0000;
      end else if (i_smem_ext && !i_smem_cen && i_smem_wen) begin
         rdata_q <= smem_q[i_smem_addr];
      end else begin
         rdata_q <= rdata_q;
      end
   end

   assign o_smem_rdata = rdata_q;
endmodule

// File: tb/tb_mult_chip.sv
// Directed self-checking bench for mult_chip: logging, pause, external access, reset behaviour.
module tb_mult_chip;
   logic        i_clk;
   logic        i_reset;
   logic        i_smem_ext;
   logic        i_smem_cen;
   logic        i_smem_wen;
   logic [11:0] i_smem_addr;
   logic [15:0] i_smem_wdata;
   logic [15:0] o_smem_rdata;

   int cmp_cnt = 0;
   int err_cnt = 0;
   logic [15:0] exp_mem [4096];

   mult_chip dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_smem_ext   (i_smem_ext),
      .i_smem_cen   (i_smem_cen),
      .i_smem_wen   (i_smem_wen),
      .i_smem_addr  (i_smem_addr),
      .i_smem_wdata (i_smem_wdata),
      .o_smem_rdata (o_smem_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      cmp_cnt++;
      assert (obs === expv) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic ext_read(input logic [11:0] a);
      i_smem_ext  = 1'b1;
      i_smem_cen  = 1'b0;
      i_smem_wen  = 1'b1;
      i_smem_addr = a;
      step(1);
      i_smem_cen  = 1'b1;
   endtask

   initial begin
      logic [15:0] l;
      l = 16'hACE1;
      for (int i = 0; i < 4096; i++) begin
         exp_mem[i] = {8'd0, l[15:8]} * {8'd0, l[7:0]};
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end

      i_reset = 1'b1; i_smem_ext = 1'b0; i_smem_cen = 1'b1; i_smem_wen = 1'b1;
      i_smem_addr = 12'd0; i_smem_wdata = 16'd0;
      #2;
      step(2);
      check("reset_rdata", o_smem_rdata, 16'h0000);

      // Log 500 cycles, then pause for 100 with external reads
      i_reset = 1'b0;
      step(500);
      i_smem_ext = 1'b1;
      ext_read(12'd0);
      check("pause_addr0", o_smem_rdata, 16'h972C);
      ext_read(12'd1);
      check("pause_addr1", o_smem_rdata, 16'h43CB);
      step(98);
      check("pause_hold", o_smem_rdata, 16'h43CB);

      // Internal logging owns the port: ext-style read strobes are ignored
      i_smem_ext = 1'b0; i_smem_cen = 1'b0; i_smem_wen = 1'b1; i_smem_addr = 12'd5;
      step(20);
      check("hold_during_log", o_smem_rdata, 16'h43CB);
      i_smem_cen = 1'b1;
      step(3700);

      for (int a = 0; a < 4096; a++) begin
         ext_read(12'(a));
         check($sformatf("dump_%0d", a), o_smem_rdata, exp_mem[a]);
      end

      // No wrap after completion
      i_smem_ext = 1'b0;
      step(8192);
      ext_read(12'd4095);
      check("nowrap_4095", o_smem_rdata, exp_mem[4095]);
      ext_read(12'd0);
      check("nowrap_0", o_smem_rdata, 16'h972C);

      // External write then read of same address
      i_smem_ext = 1'b1; i_smem_cen = 1'b0; i_smem_wen = 1'b0;
      i_smem_addr = 12'd7; i_smem_wdata = 16'hBEEF;
      step(1);
      ext_read(12'd7);
      check("wr_rd_beef", o_smem_rdata, 16'hBEEF);
      i_smem_addr = 12'd0;
      step(3);
      check("cen_hold", o_smem_rdata, 16'hBEEF);

      // Restart, then reset at logging cycle 1000 with a write attempt
      i_smem_ext = 1'b0; i_reset = 1'b1;
      step(1);
      i_reset = 1'b0;
      step(1000);
      i_reset = 1'b1; i_smem_ext = 1'b1; i_smem_cen = 1'b0; i_smem_wen = 1'b0;
      i_smem_addr = 12'd4000; i_smem_wdata = 16'h1234;
      step(2);
      check("midreset_rdata", o_smem_rdata, 16'h0000);
      i_reset = 1'b0; i_smem_ext = 1'b0; i_smem_cen = 1'b1; i_smem_wen = 1'b1;
      step(10);
      ext_read(12'd0);
      check("restart_addr0", o_smem_rdata, 16'h972C);
      ext_read(12'd7);
      check("restart_addr7", o_smem_rdata, exp_mem[7]);
      ext_read(12'd4000);
      check("no_clear_no_wr_4000", o_smem_rdata, exp_mem[4000]);

      i_smem_ext = 1'b0;
      step(4200);
      ext_read(12'd4095);
      check("rerun_4095", o_smem_rdata, exp_mem[4095]);
      ext_read(12'd2048);
      check("rerun_2048", o_smem_rdata, exp_mem[2048]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
